rsnn_spi_cfg_slave: RTL and testbench

//   SPI mode-0 slave giving the host/bench access to the RSNN weight/config memory via uio pins.

---
 rtl/rsnn_spi_pkg.sv | 22 ++
 rtl/rsnn_spi_cfg_slave_pin_sync.sv | 52 +++++
 rtl/rsnn_spi_cfg_slave.sv | 174 +++++++++++++++++
 tb/tb_rsnn_spi_cfg_slave.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rsnn_spi_pkg.sv
// rtl/rsnn_spi_pkg.sv - shared constants, FSM state type and command decode for the RSNN SPI config slave
package rsnn_spi_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_READ    = 8'h02;
  localparam logic [1:0] DUMMY_BYTES = 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDUMMY,
    RDATA,
    ERR
  } spi_state_e;

  function automatic logic cmd_is_legal(input logic [7:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/rsnn_spi_cfg_slave_pin_sync.sv
// rtl/rsnn_spi_cfg_slave_pin_sync.sv - SPI pin synchronizers with sclk/cs_n edge pulses
// Ports: clk, rst_n         system clock, async active-low reset
//        sclk_i/cs_n_i/mosi_i raw SPI pins (async to clk)
//        sclk_rise_o/sclk_fall_o, cs_fall_o/cs_rise_o  one-clk edge pulses
//        mosi_o             synchronized mosi, aligned with sclk_rise_o
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_fall_o,
  output logic cs_rise_o,
  output logic mosi_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  // The cs_n chain resets low: if the host keeps cs_n low through a reset,
  // no falling edge is seen and the slave waits for a fresh cs_n assertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise_o =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_prev_q;
  assign cs_fall_o   = ~cs_sync_q[SYNC_STAGES-1]   &  cs_prev_q;
  assign cs_rise_o   =  cs_sync_q[SYNC_STAGES-1]   & ~cs_prev_q;
  // Same pipeline depth as sclk, so this is the bit present at the sclk rise.
  assign mosi_o      =  mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rsnn_spi_cfg_slave.sv
// rtl/rsnn_spi_cfg_slave.sv - SPI mode-0 slave decoding cmd/addr frames into config memory strobes
// Ports: clk, rst_n                      system clock, async active-low reset
//        sclk_i, cs_n_i, mosi_i, miso_o  SPI pins; miso_oe_o enables the miso pad
//        mem_addr_o/mem_wdata_o/mem_we_o/mem_re_o, mem_rdata_i  memory port
//        busy_o                          frame in progress; err_o sticky bad-command flag
module rsnn_spi_cfg_slave
  import rsnn_spi_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              err_o
);

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk_i      (sclk_i),
    .cs_n_i      (cs_n_i),
    .mosi_i      (mosi_i),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .cs_fall_o   (cs_fall),
    .cs_rise_o   (cs_rise),
    .mosi_o      (mosi_s)
  );

  spi_state_e        state_q;
  logic [2:0]        bit_cnt_q;
  logic [6:0]        rx_q;
  logic [7:0]        tx_q;
  logic [7:0]        rbuf_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q, mem_re_q;
  logic              rd_pend_q;   // mem_rdata valid this cycle
  logic              load_pend_q; // next sclk fall reloads tx from rbuf
  logic              cmd_rd_q;
  logic              err_q;
  logic [1:0]        dummy_cnt_q;

  logic [7:0] rx_d;
  logic       byte_done;

  assign rx_d      = {rx_q, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= '0;
      tx_q        <= '0;
      rbuf_q      <= '0;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      load_pend_q <= 1'b0;
      cmd_rd_q    <= 1'b0;
      err_q       <= 1'b0;
      dummy_cnt_q <= 2'd0;
    end else begin
      mem_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      rd_pend_q <= mem_re_q;
      if (rd_pend_q) rbuf_q <= mem_rdata_i;

      // cs_n rise has priority over any byte completing in the same cycle.
      if (cs_rise) begin
        state_q     <= IDLE;
        bit_cnt_q   <= 3'd0;
        load_pend_q <= 1'b0;
      end else if (state_q == IDLE) begin
        if (cs_fall) begin
          state_q     <= CMD;
          bit_cnt_q   <= 3'd0;
          tx_q        <= '0;
          err_q       <= 1'b0;
          load_pend_q <= 1'b0;
          dummy_cnt_q <= 2'd0;
        end
      end else begin
        if (sclk_fall && state_q == RDATA) begin
          if (load_pend_q) begin
            tx_q        <= rbuf_q;
            load_pend_q <= 1'b0;
          end else begin
            tx_q <= {tx_q[6:0], 1'b0};
          end
        end
        if (sclk_rise) begin
          rx_q      <= rx_d[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        if (byte_done) begin
          case (state_q)
            CMD: begin
              if (cmd_is_legal(rx_d)) begin
                state_q  <= ADDR;
                cmd_rd_q <= (rx_d == CMD_READ);
              end else begin
                state_q <= ERR;
                err_q   <= 1'b1;
              end
            end
            ADDR: begin
              if (cmd_rd_q) begin
                // Prefetch the first word while the dummy byte shifts in.
                mem_re_q   <= 1'b1;
                mem_addr_q <= ADDR_W'(rx_d);
                addr_q     <= ADDR_W'(rx_d) + ADDR_W'(1);
                state_q    <= RDUMMY;
              end else begin
                addr_q  <= ADDR_W'(rx_d);
                state_q <= WDATA;
              end
            end
            WDATA: begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= addr_q;
              mem_wdata_q <= DATA_W'(rx_d);
              addr_q      <= addr_q + ADDR_W'(1);
            end
            RDUMMY: begin
              if (dummy_cnt_q == DUMMY_BYTES - 2'd1) begin
                state_q     <= RDATA;
                load_pend_q <= 1'b1;
              end else begin
                dummy_cnt_q <= dummy_cnt_q + 2'd1;
              end
            end
            RDATA: begin
              mem_re_q    <= 1'b1;
              mem_addr_q  <= addr_q;
              addr_q      <= addr_q + ADDR_W'(1);
              load_pend_q <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign miso_o      = (state_q == RDATA) && tx_q[7];
  assign busy_o      = (state_q != IDLE);
  assign miso_oe_o   = busy_o;
  assign err_o       = err_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;
  assign mem_re_o    = mem_re_q;

endmodule

// File: tb/tb_rsnn_spi_cfg_slave.sv
// tb/tb_rsnn_spi_cfg_slave.sv - self-checking bench for rsnn_spi_cfg_slave against a frame-level model
module tb_rsnn_spi_cfg_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, mem_we, mem_re, busy, err;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata;

  rsnn_spi_cfg_slave dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk_i      (sclk),
    .cs_n_i      (cs_n),
    .mosi_i      (mosi),
    .miso_o      (miso),
    .miso_oe_o   (miso_oe),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_re_o    (mem_re),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Environment memory: one-cycle read latency, cleared while in reset.
  logic [7:0] env_mem [256];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= 8'h00;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= env_mem[mem_addr];
    end
  end

  logic [15:0] we_q [$];
  logic [7:0]  re_q [$];
  int          both_cnt = 0;
  always @(negedge clk) begin
    if (mem_we) we_q.push_back({mem_addr, mem_wdata});
    if (mem_re) re_q.push_back(mem_addr);
    if (mem_we && mem_re) both_cnt++;
  end

  logic [7:0] ref_mem [256];
  logic [7:0] tx_bytes [$];
  logic [7:0] rx_bytes [$];

  // Host side, mode 0: mosi set after sclk falls, miso sampled at sclk rise.
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      #100 sclk = 1'b1;
      r[i] = miso;
      #100 sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    we_q.delete();
    re_q.delete();
    rx_bytes.delete();
    @(negedge clk);
    cs_n = 1'b0;
  endtask

  task automatic cs_high();
    #100 cs_n = 1'b1;
    mosi = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic run_frame();
    logic [7:0] r;
    cs_low();
    foreach (tx_bytes[i]) begin
      spi_bits(tx_bytes[i], 8, r);
      rx_bytes.push_back(r);
    end
    cs_high();
  endtask

  // Frame-level model: derives expected strobes and miso bytes from the bytes sent.
  task automatic check_frame(input string tag);
    logic [15:0] ewe [$];
    logic [7:0]  ere [$];
    logic [7:0]  emiso [$];
    logic [7:0]  a;
    logic [7:0]  cmd;
    int          n;
    n   = tx_bytes.size();
    cmd = tx_bytes[0];
    a   = tx_bytes[1];
    for (int i = 0; i < n; i++) emiso.push_back(8'h00);
    if (cmd == 8'h01) begin
      for (int i = 2; i < n; i++) begin
        ewe.push_back({a, tx_bytes[i]});
        ref_mem[a] = tx_bytes[i];
        a = a + 8'd1;
      end
    end else if (cmd == 8'h02) begin
      ere.push_back(a);
      for (int i = 3; i < n; i++) begin
        emiso[i] = ref_mem[a + 8'(i - 3)];
        ere.push_back(a + 8'(i - 2));
      end
    end
    chk({tag, " we_count"}, 32'(we_q.size()), 32'(ewe.size()));
    for (int i = 0; i < ewe.size() && i < we_q.size(); i++)
      chk({tag, " we_addr_data"}, 32'(we_q[i]), 32'(ewe[i]));
    chk({tag, " re_count"}, 32'(re_q.size()), 32'(ere.size()));
    for (int i = 0; i < ere.size() && i < re_q.size(); i++)
      chk({tag, " re_addr"}, 32'(re_q[i]), 32'(ere[i]));
    for (int i = 0; i < n; i++)
      chk({tag, " miso_byte"}, 32'(rx_bytes[i]), 32'(emiso[i]));
    chk({tag, " err"}, 32'(err), 32'((cmd != 8'h01) && (cmd != 8'h02)));
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] r;
    int         kind, nb;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst miso", 32'(miso), 32'd0);
    chk("rst miso_oe", 32'(miso_oe), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_re", 32'(mem_re), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write with address wrap
    tx_bytes = '{8'h01, 8'hFE, 8'hAA, 8'hBB, 8'hCC};
    run_frame();
    check_frame("write_wrap");

    // Preload 10:5A, 11:C3 then read back with one dummy byte
    tx_bytes = '{8'h01, 8'h10, 8'h5A, 8'hC3};
    run_frame();
    check_frame("preload");
    tx_bytes = '{8'h02, 8'h10, 8'h00, 8'h00, 8'h00};
    cs_low();
    foreach (tx_bytes[i]) begin
      spi_bits(tx_bytes[i], 8, r);
      rx_bytes.push_back(r);
      if (i == 0) chk("read miso_oe_in_frame", 32'(miso_oe), 32'd1);
    end
    cs_high();
    check_frame("read");
    chk("read byte3 literal", 32'(rx_bytes[3]), 32'h5A);
    chk("read byte4 literal", 32'(rx_bytes[4]), 32'hC3);

    // Illegal command, then a legal frame clears err
    tx_bytes = '{8'h7F, 8'h20, 8'h11};
    run_frame();
    check_frame("bad_cmd");
    tx_bytes = '{8'h01, 8'h30, 8'h77};
    run_frame();
    check_frame("after_bad");

    // Abort mid data byte: no strobe, then a clean frame to the same address
    cs_low();
    spi_bits(8'h01, 8, r);
    spi_bits(8'h40, 8, r);
    spi_bits(8'h99, 5, r);
    cs_high();
    chk("abort we_count", 32'(we_q.size()), 32'd0);
    tx_bytes = '{8'h01, 8'h40, 8'h99};
    run_frame();
    check_frame("after_abort");

    // Async reset in the middle of a write data byte
    cs_low();
    spi_bits(8'h01, 8, r);
    spi_bits(8'h60, 8, r);
    spi_bits(8'h11, 8, r);
    spi_bits(8'h22, 4, r);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst miso_oe", 32'(miso_oe), 32'd0);
    chk("midrst mem_we", 32'(mem_we), 32'd0);
    chk("midrst mem_addr", 32'(mem_addr), 32'd0);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    repeat (12) @(negedge clk);
    chk("midrst we_count", 32'(we_q.size()), 32'd1);
    if (we_q.size() > 0) chk("midrst first_write", 32'(we_q[0]), 32'h6011);
    tx_bytes = '{8'h01, 8'h00, 8'h55};
    run_frame();
    check_frame("after_rst");
    tx_bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame();
    check_frame("readback_rst");

    // Random frames
    for (int f = 0; f < 24; f++) begin
      kind = $urandom_range(0, 9);
      nb   = $urandom_range(2, 6);
      tx_bytes.delete();
      if (kind < 5)      tx_bytes.push_back(8'h01);
      else if (kind < 9) tx_bytes.push_back(8'h02);
      else               tx_bytes.push_back(8'($urandom_range(3, 255)));
      if (kind % 3 == 0) tx_bytes.push_back(8'($urandom_range(252, 255)));
      else               tx_bytes.push_back(8'($urandom_range(0, 15)));
      for (int i = 2; i < nb; i++) tx_bytes.push_back(8'($urandom));
      run_frame();
      check_frame($sformatf("rand%0d", f));
    end

    chk("we_re_exclusive", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
